// File: rtl/coin_tally_reporter_if.sv
// Byte stream from the tally reporter to the UART transmitter.
interface coin_tally_reporter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/coin_tally_reporter.sv
// Saturating coin counters with an ASCII decimal report frame
// streamed byte-by-byte to the UART.
module coin_tally_reporter #(
    parameter int         NUM_CH = 4,
    parameter int         CNT_W  = 8,
    parameter int         DIGITS = 3,
    parameter logic [7:0] SEP    = 8'h2C
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       coin,
    input  logic                    clear,
    input  logic                    report_req,
    coin_tally_reporter_if.master   tx,
    output logic                    busy,
    output logic                    frame_done,
    output logic [NUM_CH*CNT_W-1:0] count_flat
);
    localparam int BIN_MAX = (1 << CNT_W) - 1;
    localparam int DEC_MAX = (10 ** DIGITS) - 1;
    localparam int SAT_MAX = (BIN_MAX < DEC_MAX) ? BIN_MAX : DEC_MAX;
    localparam int BCD_W   = 4 * DIGITS;
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DG_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BIT_W   = $clog2(CNT_W);

    localparam logic [CNT_W-1:0] SAT      = SAT_MAX[CNT_W-1:0];
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CNT_W - 1);
    localparam logic [DG_W-1:0]  TOP_DG   = DG_W'(DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SNAP, S_CONV, S_SEND,
        S_SEPB, S_CR, S_LF, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q  [NUM_CH];
    logic [CNT_W-1:0] cnt_d  [NUM_CH];
    logic [CNT_W-1:0] snap_q [NUM_CH];
    logic [CNT_W-1:0] snap_d [NUM_CH];
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0] sh_q, sh_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [DG_W-1:0]  dig_q, dig_d;
    logic             txv_q, txv_d;
    logic [7:0]       txd_q, txd_d;
    logic             event_s, emit, adv;
    logic [7:0]       byte_s;

    function automatic logic [BCD_W-1:0] dabble(
        input logic [BCD_W-1:0] b
    );
        logic [BCD_W-1:0] r;
        r = b;
        for (int k = 0; k < DIGITS; k++) begin
            if (r[4*k +: 4] >= 4'd5)
                r[4*k +: 4] = r[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign bcd_adj = dabble(bcd_q);

    // A pulse at saturation is not a change, so it does not request a frame.
    always_comb begin
        event_s = clear | report_req;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear) begin
                cnt_d[i] = '0;
            end else if (coin[i] && cnt_q[i] != SAT) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
                event_s  = 1'b1;
            end
        end
    end

    always_comb begin
        pend_d = (state_q == S_SNAP) ? 1'b0 : pend_q;
        if (event_s)
            pend_d = 1'b1;
    end

    always_comb begin
        emit   = 1'b1;
        byte_s = 8'h00;
        unique case (state_q)
            S_SEND:  byte_s = 8'h30 + {4'h0, bcd_q[{dig_q, 2'b00} +: 4]};
            S_SEPB:  byte_s = SEP;
            S_CR:    byte_s = 8'h0D;
            S_LF:    byte_s = 8'h0A;
            default: emit   = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        ch_d    = ch_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        bit_d   = bit_q;
        dig_d   = dig_q;
        txv_d   = txv_q;
        txd_d   = txd_q;
        adv     = 1'b0;

        // Byte is loaded one cycle after entering an emitting state
        if (emit) begin
            if (!txv_q) begin
                txv_d = 1'b1;
                txd_d = byte_s;
            end else if (tx.tx_ready) begin
                txv_d = 1'b0;
                adv   = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (pend_q)
                    state_d = S_SNAP;
            end
            S_SNAP: begin
                snap_d  = cnt_q;
                ch_d    = '0;
                sh_d    = cnt_q[0];
                bcd_d   = '0;
                bit_d   = '0;
                state_d = S_CONV;
            end
            S_CONV: begin
                bcd_d = {bcd_adj[BCD_W-2:0], sh_q[CNT_W-1]};
                sh_d  = sh_q << 1;
                bit_d = bit_q + 1'b1;
                if (bit_q == LAST_BIT) begin
                    dig_d   = TOP_DG;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (adv) begin
                    if (dig_q != '0)
                        dig_d = dig_q - 1'b1;
                    else if (ch_q == LAST_CH)
                        state_d = S_CR;
                    else
                        state_d = S_SEPB;
                end
            end
            S_SEPB: begin
                if (adv) begin
                    ch_d    = ch_q + 1'b1;
                    sh_d    = snap_q[ch_q + 1'b1];
                    bcd_d   = '0;
                    bit_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CR: begin
                if (adv)
                    state_d = S_LF;
            end
            S_LF: begin
                if (adv)
                    state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            ch_q    <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            bit_q   <= '0;
            dig_q   <= '0;
            txv_q   <= 1'b0;
            txd_q   <= 8'h00;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ch_q    <= ch_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            bit_q   <= bit_d;
            dig_q   <= dig_d;
            txv_q   <= txv_d;
            txd_q   <= txd_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
        end
    end

    assign tx.tx_data  = txd_q;
    assign tx.tx_valid = txv_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign frame_done  = (state_q == S_DONE);

    always_comb begin
        count_flat = '0;
        for (int i = 0; i < NUM_CH; i++)
            count_flat[i*CNT_W +: CNT_W] = cnt_q[i];
    end
endmodule

// File: tb/tb_coin_tally_reporter.sv
// Randomised and directed bench for coin_tally_reporter with a
// frame-level reference model of counts, pending and frame text.
module tb_coin_tally_reporter;
    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int DG   = 3;
    localparam int SATA = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic              report_req = 1'b0;
    logic [NCH-1:0]    coin = '0;
    logic              busy, frame_done;
    logic [NCH*CW-1:0] count_flat;
    coin_tally_reporter_if txa ();

    coin_tally_reporter #(
        .NUM_CH(NCH), .CNT_W(CW), .DIGITS(DG), .SEP(8'h2C)
    ) dut_a (
        .clk(clk), .reset(reset), .coin(coin),
        .clear(clear), .report_req(report_req),
        .tx(txa.master), .busy(busy),
        .frame_done(frame_done), .count_flat(count_flat)
    );

    logic        reset_b = 1'b1;
    logic        clear_b = 1'b0;
    logic        report_b = 1'b0;
    logic [1:0]  coin_b = '0;
    logic        busy_b, done_b;
    logic [19:0] flat_b;
    coin_tally_reporter_if txb ();

    coin_tally_reporter #(
        .NUM_CH(2), .CNT_W(10), .DIGITS(4), .SEP(8'h2C)
    ) dut_b (
        .clk(clk), .reset(reset_b), .coin(coin_b),
        .clear(clear_b), .report_req(report_b),
        .tx(txb.master), .busy(busy_b),
        .frame_done(done_b), .count_flat(flat_b)
    );

    int checks = 0;
    int failures = 0;

    function automatic string vis(input string s);
        string r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0D)      r = {r, "\\r"};
            else if (s[i] == 8'h0A) r = {r, "\\n"};
            else                    r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input string act,
                         input string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got \"%s\" expected \"%s\"",
                     name, vis(act), vis(exp));
        end
    endtask

    // ---------------- reference model + compare ----------------
    int         m_cnt [NCH];
    int         snap  [NCH];
    bit         m_pend, exp_snap, in_frame, first_v;
    bit         prev_busy, prev_v, prev_rdy, prev_rst;
    logic [7:0] prev_d;
    logic [7:0] cap [$];
    int         cyc, snap_cyc, frames;
    string      last_frame, prev_frame;

    function automatic string exp_frame();
        string s = "";
        int p;
        for (int c = 0; c < NCH; c++) begin
            for (int d = DG - 1; d >= 0; d--) begin
                p = 1;
                for (int k = 0; k < d; k++) p = p * 10;
                s = $sformatf("%s%c", s, 8'h30 + (snap[c] / p) % 10);
            end
            if (c == NCH - 1) s = {s, "\r\n"};
            else              s = {s, ","};
        end
        return s;
    endfunction

    initial begin
        m_cnt = '{default: 0};
        snap  = '{default: 0};
    end

    always @(negedge clk) begin
        logic [NCH*CW-1:0] mf;
        string act;
        bit rise;
        cyc++;
        for (int i = 0; i < NCH; i++)
            mf[i*CW +: CW] = CW'(m_cnt[i]);
        if (prev_rst) begin
            chk("rst_valid", txa.tx_valid, 0);
            chk("rst_data", txa.tx_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", frame_done, 0);
        end
        chk("count_flat", count_flat, mf);
        rise = busy && !prev_busy;
        chk("snap_start", rise, exp_snap);
        if (rise) begin
            snap     = m_cnt;
            in_frame = 1;
            first_v  = 1;
            snap_cyc = cyc;
            cap.delete();
        end
        if (txa.tx_valid && first_v) begin
            chk("latency", cyc - snap_cyc, CW + 2);
            first_v = 0;
        end
        if (prev_v && !prev_rdy && !prev_rst) begin
            chk("hold_valid", txa.tx_valid, 1);
            chk("hold_data", txa.tx_data, prev_d);
        end
        if (frame_done) begin
            chk("done_in_frame", in_frame, 1);
            chk("done_busy", busy, 0);
            if (in_frame) begin
                act = "";
                foreach (cap[i]) act = $sformatf("%s%c", act, cap[i]);
                chk_s("frame", act, exp_frame());
                frames++;
                prev_frame = last_frame;
                last_frame = act;
            end
            in_frame = 0;
            cap.delete();
        end
        if (txa.tx_valid && txa.tx_ready)
            cap.push_back(txa.tx_data);
        exp_snap  = !busy && !frame_done && m_pend && !reset;
        prev_busy = busy;
        prev_v    = txa.tx_valid;
        prev_rdy  = txa.tx_ready;
        prev_d    = txa.tx_data;
        prev_rst  = reset;
        if (reset) begin
            m_cnt    = '{default: 0};
            m_pend   = 0;
            in_frame = 0;
            first_v  = 0;
            cap.delete();
        end else begin
            if (rise) m_pend = 0;
            if (clear) begin
                m_cnt  = '{default: 0};
                m_pend = 1;
            end else begin
                for (int i = 0; i < NCH; i++)
                    if (coin[i] && m_cnt[i] < SATA) begin
                        m_cnt[i]++;
                        m_pend = 1;
                    end
            end
            if (report_req) m_pend = 1;
        end
    end

    // ---------------- second configuration capture ----------------
    string str_b = "";
    string last_b = "";
    int    frames_b = 0;

    always @(negedge clk) begin
        if (reset_b) begin
            str_b = "";
        end else begin
            if (txb.tx_valid && txb.tx_ready)
                str_b = $sformatf("%s%c", str_b, txb.tx_data);
            if (done_b) begin
                last_b = str_b;
                str_b  = "";
                frames_b++;
            end
        end
    end

    // ---------------- ready driver ----------------
    int rdy_mode = 1;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       txa.tx_ready = 1'($urandom_range(1));
            1:       txa.tx_ready = 1'b1;
            default: txa.tx_ready = 1'b0;
        endcase
    end

    initial txb.tx_ready = 1'b1;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int ch, input int n);
        repeat (n) begin
            coin = '0;
            coin[ch] = 1'b1;
            step();
        end
        coin = '0;
    endtask

    task automatic req();
        report_req = 1'b1;
        step();
        report_req = 1'b0;
    endtask

    task automatic wait_idle(input int lim, input string name);
        int n = 0;
        while (n < lim &&
               (busy || frame_done || txa.tx_valid || m_pend)) begin
            step();
            n++;
        end
        chk(name, n < lim, 1);
    endtask

    task automatic wait_busy(input int lim, input string name);
        int n = 0;
        while (n < lim && !busy) begin
            step();
            n++;
        end
        chk(name, n < lim, 1);
    endtask

    task automatic wait_idle_b(input int lim, input string name);
        int n = 0;
        int q = 0;
        while (n < lim && q < 3) begin
            step();
            n++;
            if (!busy_b && !done_b && !txb.tx_valid) q++;
            else                                     q = 0;
        end
        chk(name, n < lim, 1);
    endtask

    initial begin
        int f0, n;
        logic [7:0] d0;
        repeat (3) step();
        reset   = 1'b0;
        reset_b = 1'b0;
        step();
        chk("reset_flat", count_flat, 0);

        pulse(0, 12);
        pulse(1, 5);
        pulse(3, 100);
        wait_idle(3000, "idle_basic");
        chk_s("frame_basic", last_frame, "012,005,000,100\r\n");
        chk("earlier_frames", frames > 1, 1);
        chk("flat_basic", count_flat, {8'd100, 8'd0, 8'd5, 8'd12});

        f0 = frames;
        req();
        wait_busy(10, "busy_hold");
        rdy_mode = 2;
        n = 0;
        while (n < 50 && !txa.tx_valid) begin
            step();
            n++;
        end
        chk("valid_seen", n < 50, 1);
        d0 = txa.tx_data;
        chk("first_byte", d0, 8'h30);
        repeat (10) step();
        chk("held_valid", txa.tx_valid, 1);
        chk("held_data", txa.tx_data, 8'h30);
        rdy_mode = 1;
        wait_idle(500, "idle_hold");
        chk("hold_frames", frames, f0 + 1);
        chk_s("frame_hold", last_frame, "012,005,000,100\r\n");

        pulse(2, 260);
        wait_idle(2000, "idle_sat");
        chk_s("frame_sat", last_frame, "012,005,255,100\r\n");
        f0 = frames;
        pulse(2, 5);
        wait_idle(500, "idle_sat2");
        chk("sat_no_frame", frames, f0);
        chk("sat_count", count_flat[23:16], 255);

        clear = 1'b1;
        step();
        clear = 1'b0;
        wait_idle(500, "idle_clr");
        pulse(0, 3);
        wait_idle(500, "idle_three");
        f0 = frames;
        req();
        wait_busy(10, "busy_mid");
        repeat (5) step();
        coin[0] = 1'b1;
        step();
        coin = '0;
        repeat (5) step();
        req();
        repeat (5) step();
        coin[1] = 1'b1;
        step();
        coin = '0;
        wait_idle(500, "idle_mid");
        chk("mid_frames", frames, f0 + 2);
        chk_s("frame_mid_a", prev_frame, "003,000,000,000\r\n");
        chk_s("frame_mid_b", last_frame, "004,001,000,000\r\n");

        clear   = 1'b1;
        coin[0] = 1'b1;
        step();
        clear = 1'b0;
        coin  = '0;
        wait_idle(500, "idle_clrcoin");
        chk_s("frame_clr", last_frame, "000,000,000,000\r\n");
        chk("flat_clr", count_flat, 0);

        pulse(1, 2);
        wait_idle(500, "idle_pre_rst");
        req();
        n = 0;
        while (n < 200 && cap.size() < 5) begin
            step();
            n++;
        end
        chk("reach_ch1", n < 200, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_valid", txa.tx_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_flat", count_flat, 0);
        f0 = frames;
        repeat (5) step();
        chk("abort_no_frame", frames, f0);
        req();
        wait_idle(500, "idle_post_rst");
        chk("post_rst_frames", frames, f0 + 1);
        chk_s("frame_post_rst", last_frame, "000,000,000,000\r\n");

        rdy_mode = 0;
        f0 = frames;
        repeat (3000) begin
            for (int i = 0; i < NCH; i++)
                coin[i] = ($urandom_range(7) == 0);
            report_req = ($urandom_range(40) == 0);
            clear      = ($urandom_range(400) == 0);
            reset      = ($urandom_range(1500) == 0);
            step();
        end
        coin       = '0;
        report_req = 1'b0;
        clear      = 1'b0;
        reset      = 1'b0;
        wait_idle(3000, "idle_rand");
        chk("rand_frames", frames > f0, 1);

        repeat (1026) begin
            coin_b = 2'b01;
            step();
        end
        coin_b = '0;
        wait_idle_b(3000, "idle_b");
        chk_s("frame_b", last_b, "1023,0000\r\n");
        chk("flat_b", flat_b, {10'd0, 10'd1023});
        report_b = 1'b1;
        step();
        report_b = 1'b0;
        n = 0;
        while (n < 200 && str_b.len() < 6) begin
            step();
            n++;
        end
        chk("reach_b_ch1", n < 200, 1);
        reset_b = 1'b1;
        step();
        reset_b = 1'b0;
        chk("abort_b_valid", txb.tx_valid, 0);
        chk("abort_b_busy", busy_b, 0);
        chk("abort_b_flat", flat_b, 0);
        f0 = frames_b;
        report_b = 1'b1;
        step();
        report_b = 1'b0;
        wait_idle_b(500, "idle_b2");
        chk("b_frames", frames_b, f0 + 1);
        chk_s("frame_b_zero", last_b, "0000,0000\r\n");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
